// File: rtl/regfile_pkg.sv
// Shared constants and write-port priority resolution for the multi-port register file.
// Used by the storage update and by the optional same-cycle bypass path.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int NUM_RD_DEF   = 2;
    localparam int NUM_WR_DEF   = 2;

    // Callers zero-extend their write ports to these fixed maxima.
    localparam int MAX_WR = 4;
    localparam int MAX_AW = 8;

    typedef struct packed {
        logic       hit;
        logic [1:0] port;
    } wr_sel_t;

    // Highest-indexed enabled port whose address matches target wins.
    function automatic wr_sel_t wr_select(
        input logic [MAX_WR-1:0]             en,
        input logic [MAX_WR-1:0][MAX_AW-1:0] addr,
        input logic [MAX_AW-1:0]             target
    );
        wr_sel_t sel;
        sel = '0;
        for (int i = 0; i < MAX_WR; i++) begin
            if (en[i] && (addr[i] == target)) begin
                sel.hit  = 1'b1;
                sel.port = 2'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: write-back clears, claim sets (beats a same-edge clear),
// flush clears everything and beats a same-edge claim.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [MAX_WR-1:0]               wr_en,
    input  logic [MAX_WR-1:0][MAX_AW-1:0]   wr_addr,
    input  logic                            claim_en,
    input  logic [ADDR_W-1:0]               claim_addr,
    input  logic                            flush,
    output logic [NUM_REGS-1:0]             busy_vec
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            logic busy_d;
            logic busy_q;

            always_comb begin
                busy_d = busy_q;
                for (int w = 0; w < MAX_WR; w++) begin
                    if (wr_en[w] && (wr_addr[w] == MAX_AW'(gi))) begin
                        busy_d = 1'b0;
                    end
                end
                if (claim_en && (claim_addr == ADDR_W'(gi))) begin
                    busy_d = 1'b1;
                end
                if (flush || ((ZERO_REG != 0) && (gi == 0))) begin
                    busy_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    busy_q <= 1'b0;
                end else begin
                    busy_q <= busy_d;
                end
            end

            assign busy_vec[gi] = busy_q;
        end
    endgenerate

endmodule

// File: rtl/multiport_register_file.sv
// Multi-port register file with scoreboard; combinational reads, prioritised writes.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and busy) to read ports.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int NUM_WR   = NUM_WR_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    input  logic                     flush,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [MAX_WR-1:0]             wr_en_ext;
    logic [MAX_WR-1:0][MAX_AW-1:0] wr_addr_ext;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_all;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_WR; gi++) begin : g_wr_ext
            if (gi < NUM_WR) begin : g_used
                assign wr_en_ext[gi]   = wr_en[gi];
                assign wr_addr_ext[gi] = MAX_AW'(wr_addr[gi*ADDR_W +: ADDR_W]);
            end else begin : g_unused
                assign wr_en_ext[gi]   = 1'b0;
                assign wr_addr_ext[gi] = '0;
            end
        end

        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            wr_sel_t           sel;
            logic [DATA_W-1:0] reg_d;
            logic [DATA_W-1:0] reg_q;

            always_comb begin
                sel   = wr_select(wr_en_ext, wr_addr_ext, MAX_AW'(gi));
                reg_d = reg_q;
                if (sel.hit && !((ZERO_REG != 0) && (gi == 0))) begin
                    reg_d = wr_data[sel.port*DATA_W +: DATA_W];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs_all[gi] = reg_q;
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] data;
            logic              busy;
`ifdef REGFILE_BYPASS_EN
            wr_sel_t           fwd;
`endif

            assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                data = regs_all[addr];
                busy = busy_vec[addr];
`ifdef REGFILE_BYPASS_EN
                fwd = wr_select(wr_en_ext, wr_addr_ext, MAX_AW'(addr));
                // Forwarding is suppressed in reset so every port reads 0 while it is held.
                if (reset && fwd.hit && !((ZERO_REG != 0) && (addr == '0))) begin
                    data = wr_data[fwd.port*DATA_W +: DATA_W];
                    busy = claim_en && (claim_addr == addr);
                end
`endif
            end

            assign rd_data[gi*DATA_W +: DATA_W] = data;
            assign rd_busy[gi]                  = busy;
        end
    endgenerate

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en_ext),
        .wr_addr    (wr_addr_ext),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .flush      (flush),
        .busy_vec   (busy_vec)
    );

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed scenarios on the default configuration plus randomized runs of the default
// and a 16x64, 4-read, 3-write configuration against a behavioural register-file model.
module tb_multiport_register_file;

    logic        clk;
    logic        reset;

    // default configuration: 32 x 32, 2 read, 2 write
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic        flush;
    logic [31:0] busy_vec;

    // swept configuration: 16 x 64, 4 read, 3 write
    logic [15:0]  s_rd_addr;
    logic [255:0] s_rd_data;
    logic [3:0]   s_rd_busy;
    logic [2:0]   s_wr_en;
    logic [11:0]  s_wr_addr;
    logic [191:0] s_wr_data;
    logic         s_claim_en;
    logic [3:0]   s_claim_addr;
    logic         s_flush;
    logic [15:0]  s_busy_vec;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_mem  [256];
    bit          m_busy [256];

    multiport_register_file dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .flush      (flush),
        .busy_vec   (busy_vec)
    );

    multiport_register_file #(
        .DATA_W   (64),
        .NUM_REGS (16),
        .NUM_RD   (4),
        .NUM_WR   (3)
    ) dut_sweep (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (s_rd_addr),
        .rd_data    (s_rd_data),
        .rd_busy    (s_rd_busy),
        .wr_en      (s_wr_en),
        .wr_addr    (s_wr_addr),
        .wr_data    (s_wr_data),
        .claim_en   (s_claim_en),
        .claim_addr (s_claim_addr),
        .flush      (s_flush),
        .busy_vec   (s_busy_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
        s_wr_en = '0; s_wr_addr = '0; s_wr_data = '0;
        s_claim_en = 1'b0; s_claim_addr = '0; s_flush = 1'b0;
    endtask

    task automatic test_reset();
        rd_addr = {5'd0, 5'd5};
        #1;
        checks++;
        if (rd_data !== 64'h0) begin
            errors++; $display("FAIL reset_hold_data: got %h expected %h", rd_data, 64'h0);
        end
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++; $display("FAIL reset_hold_busy: got %h expected %h", busy_vec, 32'h0);
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        claim_en = 1'b1; claim_addr = 5'd6;
        @(posedge clk); #1; idle();
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL reset_pre_write: got %h expected %h", rd_data[31:0], 32'hDEADBEEF);
        end
        checks++;
        if (busy_vec !== 32'h0000_0040) begin
            errors++; $display("FAIL reset_pre_busy: got %h expected %h", busy_vec, 32'h40);
        end
        #2; reset = 1'b0; #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            errors++; $display("FAIL reset_async_data: got %h expected %h", rd_data[31:0], 32'h0);
        end
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++; $display("FAIL reset_async_busy: got %h expected %h", busy_vec, 32'h0);
        end
        @(negedge clk); reset = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_write_conflict();
        @(negedge clk);
        rd_addr = {5'd0, 5'd7};
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
        @(posedge clk); #1; idle();
        checks++;
        if (rd_data[31:0] !== 32'h22) begin
            errors++; $display("FAIL write_conflict: got %h expected %h", rd_data[31:0], 32'h22);
        end
        $display("test_write_conflict done");
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        rd_addr = {5'd1, 5'd0};
        wr_en = 2'b11; wr_addr = {5'd1, 5'd0}; wr_data = {32'h0000_0005, 32'hFFFF_FFFF};
        claim_en = 1'b1; claim_addr = 5'd0;
        @(posedge clk); #1; idle();
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            errors++; $display("FAIL zero_reg_data: got %h expected %h", rd_data[31:0], 32'h0);
        end
        checks++;
        if (busy_vec[0] !== 1'b0 || rd_busy[0] !== 1'b0) begin
            errors++; $display("FAIL zero_reg_busy: got %b/%b expected 0/0", busy_vec[0], rd_busy[0]);
        end
        checks++;
        if (rd_data[63:32] !== 32'h5) begin
            errors++; $display("FAIL zero_reg_r1: got %h expected %h", rd_data[63:32], 32'h5);
        end
        $display("test_zero_reg done");
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        rd_addr = {5'd10, 5'd3};
        claim_en = 1'b1; claim_addr = 5'd3;
        @(posedge clk); #1; idle();
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++; $display("FAIL sb_claim_c1: got %b expected 1", rd_busy[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++; $display("FAIL sb_claim_c2: got %b expected 1", rd_busy[0]);
        end
        @(negedge clk);
        wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h33, 32'h0};
        @(posedge clk); #1; idle();
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h33) begin
            errors++; $display("FAIL sb_writeback: got busy %b data %h expected busy 0 data %h", rd_busy[0], rd_data[31:0], 32'h33);
        end
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h44};
        claim_en = 1'b1; claim_addr = 5'd3;
        @(posedge clk); #1; idle();
        checks++;
        if (busy_vec[3] !== 1'b1 || rd_data[31:0] !== 32'h44) begin
            errors++; $display("FAIL sb_claim_vs_write: got busy %b data %h expected busy 1 data %h", busy_vec[3], rd_data[31:0], 32'h44);
        end
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'h1010};
        claim_en = 1'b1; claim_addr = 5'd9; flush = 1'b1;
        @(posedge clk); #1; idle();
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++; $display("FAIL sb_flush: got %h expected %h", busy_vec, 32'h0);
        end
        checks++;
        if (rd_data[63:32] !== 32'h1010) begin
            errors++; $display("FAIL sb_flush_write: got %h expected %h", rd_data[63:32], 32'h1010);
        end
        $display("test_scoreboard done");
    endtask

    task automatic test_bypass();
        logic [31:0] exp_d;
        logic        exp_b;
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h1111};
        claim_en = 1'b1; claim_addr = 5'd4;
        @(posedge clk); #1; idle();
        @(negedge clk);
        rd_addr = {5'd0, 5'd4};
        wr_en = 2'b11; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0BAD, 32'hCAFE0004};
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'hCAFE0004; exp_b = 1'b0;
`else
        exp_d = 32'h1111; exp_b = 1'b1;
`endif
        checks++;
        if (rd_data[31:0] !== exp_d || rd_busy[0] !== exp_b) begin
            errors++; $display("FAIL bypass_same_cycle: got data %h busy %b expected data %h busy %b", rd_data[31:0], rd_busy[0], exp_d, exp_b);
        end
        checks++;
        if (rd_data[63:32] !== 32'h0) begin
            errors++; $display("FAIL bypass_r0: got %h expected %h", rd_data[63:32], 32'h0);
        end
        @(posedge clk); #1; idle();
        checks++;
        if (rd_data[31:0] !== 32'hCAFE0004 || rd_busy[0] !== 1'b0) begin
            errors++; $display("FAIL bypass_next_cycle: got data %h busy %b expected data %h busy 0", rd_data[31:0], rd_busy[0], 32'hCAFE0004);
        end
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h5555};
        claim_en = 1'b1; claim_addr = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'h5555; exp_b = 1'b1;
`else
        exp_d = 32'hCAFE0004; exp_b = 1'b0;
`endif
        checks++;
        if (rd_data[31:0] !== exp_d || rd_busy[0] !== exp_b) begin
            errors++; $display("FAIL bypass_with_claim: got data %h busy %b expected data %h busy %b", rd_data[31:0], rd_busy[0], exp_d, exp_b);
        end
        @(posedge clk); #1; idle();
        checks++;
        if (rd_data[31:0] !== 32'h5555 || rd_busy[0] !== 1'b1) begin
            errors++; $display("FAIL bypass_claim_after: got data %h busy %b expected data %h busy 1", rd_data[31:0], rd_busy[0], 32'h5555);
        end
        $display("test_bypass done");
    endtask

    // Random traffic against the model; sweep selects the 16x64 4R/3W instance.
    task automatic run_random(input bit sweep, input int cycles);
        int          nr, nrd, nwr, hi, fails_before;
        int          ra [4];
        bit          we [3];
        int          wa [3];
        logic [63:0] wd [3];
        bit          ce, fl;
        int          ca;
        logic [63:0] exp_d, act_d;
        logic        exp_b, act_b;
        logic [31:0] exp_bv, act_bv;

        nr  = sweep ? 16 : 32;
        nrd = sweep ? 4 : 2;
        nwr = sweep ? 3 : 2;
        fails_before = errors;

        @(negedge clk); reset = 1'b0; idle();
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end

        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            hi = (($urandom % 4) == 0) ? 3 : nr - 1;
            for (int p = 0; p < nrd; p++) ra[p] = $urandom_range(0, hi);
            for (int w = 0; w < nwr; w++) begin
                we[w] = 1'($urandom % 2);
                wa[w] = $urandom_range(0, hi);
                wd[w] = {$urandom, $urandom};
                if (!sweep) wd[w][63:32] = '0;
            end
            ce = 1'($urandom % 2);
            ca = $urandom_range(0, hi);
            fl = (($urandom % 16) == 0);

            if (sweep) begin
                for (int p = 0; p < nrd; p++) s_rd_addr[p*4 +: 4] = 4'(ra[p]);
                for (int w = 0; w < nwr; w++) begin
                    s_wr_en[w] = we[w]; s_wr_addr[w*4 +: 4] = 4'(wa[w]); s_wr_data[w*64 +: 64] = wd[w];
                end
                s_claim_en = ce; s_claim_addr = 4'(ca); s_flush = fl;
            end else begin
                for (int p = 0; p < nrd; p++) rd_addr[p*5 +: 5] = 5'(ra[p]);
                for (int w = 0; w < nwr; w++) begin
                    wr_en[w] = we[w]; wr_addr[w*5 +: 5] = 5'(wa[w]); wr_data[w*32 +: 32] = wd[w][31:0];
                end
                claim_en = ce; claim_addr = 5'(ca); flush = fl;
            end
            #1;

            for (int p = 0; p < nrd; p++) begin
                exp_d = m_mem[ra[p]];
                exp_b = m_busy[ra[p]];
`ifdef REGFILE_BYPASS_EN
                if (ra[p] != 0) begin
                    for (int w = 0; w < nwr; w++) begin
                        if (we[w] && wa[w] == ra[p]) begin
                            exp_d = wd[w];
                            exp_b = ce && (ca == ra[p]);
                        end
                    end
                end
`endif
                act_d = sweep ? s_rd_data[p*64 +: 64] : {32'h0, rd_data[p*32 +: 32]};
                act_b = sweep ? s_rd_busy[p] : rd_busy[p];
                checks++;
                if (act_d !== exp_d) begin
                    errors++;
                    $display("FAIL rand_data sweep=%0d cyc=%0d port=%0d r%0d: got %h expected %h", sweep, cyc, p, ra[p], act_d, exp_d);
                end
                checks++;
                if (act_b !== exp_b) begin
                    errors++;
                    $display("FAIL rand_busy sweep=%0d cyc=%0d port=%0d r%0d: got %b expected %b", sweep, cyc, p, ra[p], act_b, exp_b);
                end
            end
            exp_bv = '0;
            for (int r = 0; r < nr; r++) exp_bv[r] = m_busy[r];
            act_bv = sweep ? {16'h0, s_busy_vec} : busy_vec;
            checks++;
            if (act_bv !== exp_bv) begin
                errors++;
                $display("FAIL rand_busy_vec sweep=%0d cyc=%0d: got %h expected %h", sweep, cyc, act_bv, exp_bv);
            end

            // state as it stands after the coming edge
            for (int w = 0; w < nwr; w++) begin
                if (we[w] && wa[w] != 0) m_mem[wa[w]] = wd[w];
                if (we[w]) m_busy[wa[w]] = 1'b0;
            end
            if (ce && ca != 0) m_busy[ca] = 1'b1;
            if (fl) for (int r = 0; r < nr; r++) m_busy[r] = 1'b0;
        end
        @(negedge clk); idle();
        $display("run_random sweep=%0d: %0d cycles, %0d new errors", sweep, cycles, errors - fails_before);
    endtask

    task automatic test_random_default();
        run_random(1'b0, 3000);
    endtask

    task automatic test_param_sweep();
        run_random(1'b1, 10000);
    endtask

    initial begin
        reset = 1'b0;
        rd_addr = '0;
        s_rd_addr = '0;
        idle();
        test_reset();
        test_write_conflict();
        test_zero_reg();
        test_scoreboard();
        test_bypass();
        test_random_default();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
